// File: rtl/key_mode_pkg.sv
// Shared constants and state encoding for the push-button blink-rate mode controller.
package key_mode_pkg;

    localparam int unsigned CNT_W = 20;
    localparam int unsigned HP_W  = 24;
    localparam int unsigned MODE_W = 2;

    localparam int unsigned DEF_DEBOUNCE_CNT = 1000000;
    localparam int unsigned DEF_HP_MODE0     = 12500000;
    localparam int unsigned DEF_HP_MODE1     = 6250000;
    localparam int unsigned DEF_HP_MODE2     = 3125000;
    localparam int unsigned DEF_HP_MODE3     = 1562500;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        DOWN       = 2'd2,
        RELEASE_DB = 2'd3
    } db_state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low push-button and emits one strobe per qualified press.
module key_debounce
    import key_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic             sync_1;
    logic             key_s;
    db_state_t        state;
    db_state_t        next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             next_pulse;

    // Flops reset high so a button held through reset reads as released first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            key_s  <= 1'b1;
        end else begin
            sync_1 <= key_in;
            key_s  <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            key_pulse <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            key_pulse <= next_pulse;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_pulse = 1'b0;
        case (state)
            IDLE: begin
                next_cnt = '0;
                if (!key_s) begin
                    next_state = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (key_s) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = DOWN;
                    next_cnt   = '0;
                    next_pulse = 1'b1;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                next_cnt = '0;
                if (key_s) begin
                    next_state = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (!key_s) begin
                    next_state = DOWN;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_mode_ctrl.sv
// Cycles a 2-bit blink-rate mode on each qualified key press and looks up the LED half-period.
module key_mode_ctrl
    import key_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int unsigned HP_MODE0     = DEF_HP_MODE0,
    parameter int unsigned HP_MODE1     = DEF_HP_MODE1,
    parameter int unsigned HP_MODE2     = DEF_HP_MODE2,
    parameter int unsigned HP_MODE3     = DEF_HP_MODE3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_in,
    output logic              key_pulse,
    output logic [MODE_W-1:0] mode,
    output logic [HP_W-1:0]   half_period
);

    key_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_pulse(key_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= '0;
        end else if (key_pulse) begin
            mode <= mode + MODE_W'(1);
        end
    end

    // Registered lookup keeps the downstream terminal count glitch-free; it trails mode by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_period <= HP_W'(HP_MODE0);
        end else begin
            case (mode)
                2'd0:    half_period <= HP_W'(HP_MODE0);
                2'd1:    half_period <= HP_W'(HP_MODE1);
                2'd2:    half_period <= HP_W'(HP_MODE2);
                default: half_period <= HP_W'(HP_MODE3);
            endcase
        end
    end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with a run-length press model checked every cycle.
module tb_key_mode_ctrl;
    import key_mode_pkg::*;

    localparam int D = 10;
    localparam int unsigned HP_TAB [4] = '{12500000, 6250000, 3125000, 1562500};

    logic        clk;
    logic        rst_n;
    logic        key_in;
    logic        key_pulse;
    logic [1:0]  mode;
    logic [23:0] half_period;

    int tests;
    int fails;
    int steps;
    int pulses;
    int first_pulse;

    key_mode_ctrl #(
        .DEBOUNCE_CNT(D)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_pulse  (key_pulse),
        .mode       (mode),
        .half_period(half_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A press qualifies after D+1 consecutive low samples while armed; D+1 high samples re-arm.
    logic        m_s1, m_s2;
    int          low_run, high_run;
    logic        armed;
    logic        exp_pulse;
    logic [1:0]  exp_mode;
    logic [23:0] exp_hp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1      <= 1'b1;
            m_s2      <= 1'b1;
            low_run   <= 0;
            high_run  <= 0;
            armed     <= 1'b1;
            exp_pulse <= 1'b0;
            exp_mode  <= 2'd0;
            exp_hp    <= 24'(HP_TAB[0]);
        end else begin
            int   lr, hr;
            logic arm, p;
            m_s1 <= key_in;
            m_s2 <= m_s1;
            lr   = (m_s2 == 1'b0) ? low_run + 1 : 0;
            hr   = (m_s2 == 1'b1) ? high_run + 1 : 0;
            arm  = armed;
            p    = arm && (lr == D + 1);
            if (p) arm = 1'b0;
            if (!arm && hr == D + 1) arm = 1'b1;
            low_run   <= lr;
            high_run  <= hr;
            armed     <= arm;
            exp_pulse <= p;
            exp_mode  <= exp_mode + (exp_pulse ? 2'd1 : 2'd0);
            exp_hp    <= 24'(HP_TAB[exp_mode]);
        end
    end

    always @(negedge clk) begin
        tests++;
        if (key_pulse !== exp_pulse) begin
            fails++;
            $display("[TB] FAIL cyc_pulse t=%0t got %b want %b", $time, key_pulse, exp_pulse);
        end
        tests++;
        if (mode !== exp_mode) begin
            fails++;
            $display("[TB] FAIL cyc_mode t=%0t got %0d want %0d", $time, mode, exp_mode);
        end
        tests++;
        if (half_period !== exp_hp) begin
            fails++;
            $display("[TB] FAIL cyc_hp t=%0t got %0d want %0d", $time, half_period, exp_hp);
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic mark();
        steps       = 0;
        pulses      = 0;
        first_pulse = 0;
    endtask

    task automatic apply_stimulus(input logic level, input int n);
        key_in = level;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            steps++;
            if (key_pulse) begin
                pulses++;
                if (first_pulse == 0) first_pulse = steps;
            end
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        key_in = 1'b1;
        rst_n  = 1'b0;
        mark();
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_pulse", int'(key_pulse), 0);
        check_output("reset_mode", int'(mode), 0);
        check_output("reset_hp", int'(half_period), 12500000);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 5);

        // Short glitch is rejected.
        mark();
        apply_stimulus(1'b0, 5);
        apply_stimulus(1'b1, 20);
        check_output("glitch_pulses", pulses, 0);
        check_output("glitch_mode", int'(mode), 0);

        // First press: strobe after edge 13, mode then half-period one cycle apart.
        mark();
        apply_stimulus(1'b0, 14);
        check_output("press1_first_edge", first_pulse, 13);
        check_output("press1_mode", int'(mode), 1);
        check_output("press1_hp_before", int'(half_period), 12500000);
        apply_stimulus(1'b0, 1);
        check_output("press1_hp_after", int'(half_period), 6250000);
        apply_stimulus(1'b0, 25);
        apply_stimulus(1'b1, 20);
        check_output("press1_pulses", pulses, 1);

        // Three more presses walk the mode through 2, 3 and back to 0.
        for (int k = 2; k <= 4; k++) begin
            mark();
            apply_stimulus(1'b0, 40);
            apply_stimulus(1'b1, 20);
            check_output("press_seq_pulses", pulses, 1);
            check_output("press_seq_mode", int'(mode), k % 4);
            check_output("press_seq_hp", int'(half_period), int'(HP_TAB[k % 4]));
        end
        check_output("wrap_hp", int'(half_period), 12500000);

        // Release bounce yields a single press.
        mark();
        apply_stimulus(1'b0, 20);
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 2);
        apply_stimulus(1'b1, 20);
        check_output("bounce_pulses", pulses, 1);
        check_output("bounce_mode", int'(mode), 1);
        check_output("bounce_state", int'(u_dut.u_debounce.state), int'(IDLE));

        // Long hold gives exactly one strobe.
        mark();
        apply_stimulus(1'b0, 1000);
        apply_stimulus(1'b1, 20);
        check_output("hold_pulses", pulses, 1);
        check_output("hold_mode", int'(mode), 2);

        // Reset mid-debounce discards the press; the held key requalifies afterwards.
        mark();
        apply_stimulus(1'b0, 9);
        check_output("mid_db_cnt", int'(u_dut.u_debounce.cnt), 6);
        rst_n = 1'b0;
        #1;
        check_output("rst_pulse", int'(key_pulse), 0);
        check_output("rst_mode", int'(mode), 0);
        check_output("rst_hp", int'(half_period), 12500000);
        repeat (2) @(posedge clk);
        #1;
        mark();
        rst_n = 1'b1;
        apply_stimulus(1'b0, 20);
        check_output("rst_req_first_edge", first_pulse, 13);
        check_output("rst_req_pulses", pulses, 1);
        check_output("rst_req_mode", int'(mode), 1);
        apply_stimulus(1'b1, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
